// File: rtl/ce_mp.sv
// Multi-pass convolution element: CL_PAR x KERNEL^2 MACs per beat, accumulated onto a bias over a group.
// Latency 2 from the sampled last beat to en_out; 1 beat/clk, no backpressure (producer must pace itself).
module ce_mp #(
  parameter int CL_PAR = 4,
  parameter int KERNEL = 3,
  parameter int N      = 8,
  parameter int M      = 8,
  parameter int ACC_W  = 32,
  parameter int RELU   = 1,
  parameter int SR     = 4,
  parameter int OUT_W  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en_in,
  input  logic                             first_in,
  input  logic                             last_in,
  input  logic [CL_PAR*KERNEL*KERNEL*N-1:0] data2conv,
  input  logic [CL_PAR*KERNEL*KERNEL*M-1:0] w,
  input  logic [ACC_W-1:0]                 bias,
  output logic [OUT_W-1:0]                 d_out,
  output logic                             en_out,
  output logic                             sat_out,
  output logic                             err_out,
  output logic                             busy
);

  localparam int NP     = CL_PAR * KERNEL * KERNEL;
  localparam int PW     = N + M;
  localparam int RND_SH = (SR > 0) ? SR - 1 : 0;

  localparam logic signed [ACC_W:0] RND  = (SR > 0) ? ((ACC_W+1)'(1) << RND_SH) : (ACC_W+1)'(0);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, OPEN} state_t;

  state_t                   state_q;
  logic                     err_q;
  logic                     accept;
  logic                     proto_err;

  logic                     s1_vld_q;
  logic                     s1_first_q;
  logic                     s1_last_q;
  logic signed [ACC_W-1:0]  s1_bias_q;
  logic signed [PW-1:0]     prod_d [NP];
  logic signed [PW-1:0]     prod_q [NP];

  logic                     s2_vld_q;
  logic                     s2_first_q;
  logic                     s2_last_q;
  logic signed [ACC_W-1:0]  s2_bias_q;
  logic signed [ACC_W-1:0]  sum_d;
  logic signed [ACC_W-1:0]  s2_sum_q;

  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W:0]    relu_v;
  logic signed [ACC_W:0]    shift_v;
  logic [OUT_W-1:0]         d_out_d;
  logic                     sat_d;
  logic [OUT_W-1:0]         d_out_q;
  logic                     en_out_q;
  logic                     sat_q;

  // A beat with no open group and no first flag is dropped at the door.
  assign accept    = en_in && (first_in || (state_q == OPEN));
  assign proto_err = en_in && (first_in ? (state_q == OPEN) : (state_q == IDLE));

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      prod_d[i] = PW'($signed(data2conv[i*N +: N])) * PW'($signed(w[i*M +: M]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bias_q  <= '0;
      for (int i = 0; i < NP; i++) prod_q[i] <= '0;
    end else begin
      s1_vld_q <= accept;
      if (proto_err) err_q <= 1'b1;
      if (accept) begin
        state_q    <= last_in ? IDLE : OPEN;
        s1_first_q <= first_in;
        s1_last_q  <= last_in;
        s1_bias_q  <= bias;
        for (int i = 0; i < NP; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NP; i++) begin
      sum_d = sum_d + ACC_W'(prod_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_bias_q  <= '0;
      s2_sum_q   <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
        s2_bias_q  <= s1_bias_q;
        s2_sum_q   <= sum_d;
      end
    end
  end

  // A first beat reloads from bias, which also discards an aborted group.
  always_comb begin
    acc_d = acc_q;
    if (s2_vld_q) begin
      acc_d = (s2_first_q ? s2_bias_q : acc_q) + s2_sum_q;
    end
  end

  always_comb begin
    relu_v = {acc_d[ACC_W-1], acc_d};
    if ((RELU != 0) && acc_d[ACC_W-1]) relu_v = '0;
    shift_v = (relu_v + RND) >>> SR;
    d_out_d = shift_v[OUT_W-1:0];
    sat_d   = 1'b0;
    if (shift_v > MAXV) begin
      d_out_d = MAXV[OUT_W-1:0];
      sat_d   = 1'b1;
    end else if (shift_v < MINV) begin
      d_out_d = MINV[OUT_W-1:0];
      sat_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      d_out_q  <= '0;
      en_out_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      en_out_q <= s2_vld_q && s2_last_q;
      if (s2_vld_q && s2_last_q) begin
        d_out_q <= d_out_d;
        sat_q   <= sat_d;
      end
    end
  end

  assign d_out   = d_out_q;
  assign en_out  = en_out_q;
  assign sat_out = sat_q;
  assign err_out = err_q;
  assign busy    = (state_q == OPEN) || s1_vld_q || s2_vld_q;

endmodule

// File: tb/tb_ce_mp.sv
// Bench for ce_mp: two instances (RELU=1 and RELU=0) share stimulus; a scoreboard queue per instance.
module tb_ce_mp;

  localparam int CL_PAR = 4;
  localparam int KERNEL = 3;
  localparam int N      = 8;
  localparam int M      = 8;
  localparam int ACC_W  = 32;
  localparam int SR     = 4;
  localparam int OUT_W  = 8;
  localparam int NP     = CL_PAR * KERNEL * KERNEL;
  localparam int DW     = NP * N;
  localparam int WW     = NP * M;

  logic             clk;
  logic             rst;
  logic             en_in;
  logic             first_in;
  logic             last_in;
  logic [DW-1:0]    data2conv;
  logic [WW-1:0]    w;
  logic [ACC_W-1:0] bias;
  logic [OUT_W-1:0] d_out1, d_out0;
  logic             en_out1, en_out0;
  logic             sat_out1, sat_out0;
  logic             err_out1, err_out0;
  logic             busy1, busy0;

  ce_mp #(.CL_PAR(CL_PAR), .KERNEL(KERNEL), .N(N), .M(M), .ACC_W(ACC_W),
          .RELU(1), .SR(SR), .OUT_W(OUT_W)) u_dut (
    .clk(clk), .rst(rst), .en_in(en_in), .first_in(first_in), .last_in(last_in),
    .data2conv(data2conv), .w(w), .bias(bias),
    .d_out(d_out1), .en_out(en_out1), .sat_out(sat_out1), .err_out(err_out1), .busy(busy1));

  ce_mp #(.CL_PAR(CL_PAR), .KERNEL(KERNEL), .N(N), .M(M), .ACC_W(ACC_W),
          .RELU(0), .SR(SR), .OUT_W(OUT_W)) u_dut0 (
    .clk(clk), .rst(rst), .en_in(en_in), .first_in(first_in), .last_in(last_in),
    .data2conv(data2conv), .w(w), .bias(bias),
    .d_out(d_out0), .en_out(en_out0), .sat_out(sat_out0), .err_out(err_out0), .busy(busy0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic signed [63:0] dout;
    logic               sat;
    int                 cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  bit     m_open = 1'b0;
  bit     m_err  = 1'b0;
  longint m_acc  = 0;

  function automatic void post(input longint acc, input bit relu, output longint d, output bit s);
    longint v;
    longint vmax;
    longint vmin;
    v    = acc;
    vmax = (longint'(1) << (OUT_W - 1)) - 1;
    vmin = -(longint'(1) << (OUT_W - 1));
    if (relu && v < 0) v = 0;
    if (SR > 0) v = (v + (longint'(1) << (SR - 1))) >>> SR;
    s = 1'b1;
    if (v > vmax) d = vmax;
    else if (v < vmin) d = vmin;
    else begin
      d = v;
      s = 1'b0;
    end
  endfunction

  function automatic logic [DW-1:0] fill_d(input int v);
    logic [DW-1:0] r;
    logic [N-1:0]  e;
    e = v[N-1:0];
    for (int i = 0; i < NP; i++) r[i*N +: N] = e;
    return r;
  endfunction

  function automatic logic [WW-1:0] fill_w(input int v);
    logic [WW-1:0] r;
    logic [M-1:0]  e;
    e = v[M-1:0];
    for (int i = 0; i < NP; i++) r[i*M +: M] = e;
    return r;
  endfunction

  task automatic beat(input bit f, input bit l, input logic [DW-1:0] dv,
                      input logic [WW-1:0] wv, input longint b);
    longint s;
    longint d;
    bit     sat;
    exp_t   e;
    @(negedge clk);
    en_in     = 1'b1;
    first_in  = f;
    last_in   = l;
    data2conv = dv;
    w         = wv;
    bias      = b[ACC_W-1:0];
    s = 0;
    for (int i = 0; i < NP; i++) begin
      s += longint'($signed(dv[i*N +: N])) * longint'($signed(wv[i*M +: M]));
    end
    if (!m_open && !f) begin
      m_err = 1'b1;
    end else begin
      if (m_open && f) m_err = 1'b1;
      m_acc  = f ? (b + s) : (m_acc + s);
      m_open = !l;
      if (l) begin
        post(m_acc, 1'b1, d, sat);
        e.dout = d; e.sat = sat; e.cyc = cyc + 3;
        q1.push_back(e);
        post(m_acc, 1'b0, d, sat);
        e.dout = d; e.sat = sat; e.cyc = cyc + 3;
        q0.push_back(e);
      end
    end
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(negedge clk);
      en_in    = 1'b0;
      first_in = 1'b0;
      last_in  = 1'b0;
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (en_out1 === 1'b1) begin
      if (q1.size() == 0) check("unexpected_out_relu1", 1, 0);
      else begin
        e = q1.pop_front();
        check("dout_relu1", $signed(d_out1), e.dout);
        check("sat_relu1", sat_out1, e.sat);
        check("latency_relu1", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (en_out0 === 1'b1) begin
      if (q0.size() == 0) check("unexpected_out_relu0", 1, 0);
      else begin
        e = q0.pop_front();
        check("dout_relu0", $signed(d_out0), e.dout);
        check("sat_relu0", sat_out0, e.sat);
        check("latency_relu0", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en_in = 1'b0; first_in = 1'b0; last_in = 1'b0;
    data2conv = '0; w = '0; bias = '0;
    repeat (3) @(negedge clk);
    check("rst_dout", $signed(d_out1), 0);
    check("rst_en_out", en_out1, 0);
    check("rst_err", err_out1, 0);
    check("rst_busy", busy1, 0);
    rst = 1'b1;
    bubble(2);

    // single pass
    beat(1, 1, fill_d(1), fill_w(1), 0);
    bubble(1);
    check("busy_in_flight", busy1, 1);
    bubble(4);
    check("single_dout", $signed(d_out1), 2);
    check("single_err", err_out1, 0);

    // three passes with bubbles inside the group
    beat(1, 0, fill_d(1), fill_w(2), 16);
    beat(0, 0, fill_d(1), fill_w(2), 0);
    bubble(2);
    check("busy_open", busy1, 1);
    beat(0, 1, fill_d(1), fill_w(2), 0);
    bubble(5);
    check("multi_dout", $signed(d_out1), 15);
    check("multi_busy_idle", busy1, 0);

    // negative sum, with and without ReLU
    beat(1, 1, fill_d(1), fill_w(-1), 0);
    bubble(4);
    check("neg_relu1", $signed(d_out1), 0);
    check("neg_relu0", $signed(d_out0), -2);

    // saturation both directions
    beat(1, 1, fill_d(127), fill_w(127), 0);
    bubble(4);
    check("sat_pos_dout", $signed(d_out1), 127);
    beat(1, 1, fill_d(127), fill_w(-128), 0);
    bubble(4);
    check("sat_neg_dout", $signed(d_out0), -128);

    // protocol errors
    beat(0, 0, fill_d(3), fill_w(3), 0);
    bubble(4);
    check("err_idle_beat", err_out1, m_err);
    check("err_idle_beat_r0", err_out0, m_err);
    beat(1, 0, fill_d(1), fill_w(1), 100);
    beat(1, 0, fill_d(1), fill_w(2), 16);
    beat(0, 1, fill_d(1), fill_w(2), 0);
    bubble(5);
    check("restart_dout", $signed(d_out1), 10);
    check("restart_err", err_out1, 1);

    // random multi-pass groups with small signed operands
    for (int g = 0; g < 6; g++) begin
      int passes;
      passes = $urandom_range(1, 4);
      for (int p = 0; p < passes; p++) begin
        logic [DW-1:0] dv;
        logic [WW-1:0] wv;
        longint        b;
        for (int i = 0; i < NP; i++) begin
          dv[i*N +: N] = N'($urandom_range(0, 15) - 8);
          wv[i*M +: M] = M'($urandom_range(0, 15) - 8);
        end
        b = longint'($urandom_range(0, 4000)) - 2000;
        beat(p == 0, p == passes - 1, dv, wv, b);
        bubble($urandom_range(0, 2));
      end
      bubble(4);
    end

    // reset in the middle of a group
    beat(1, 0, fill_d(1), fill_w(1), 5);
    @(negedge clk);
    en_in = 1'b0; first_in = 1'b0; last_in = 1'b0;
    rst = 1'b0;
    m_open = 1'b0;
    m_err  = 1'b0;
    @(negedge clk);
    check("midrst_err", err_out1, 0);
    check("midrst_busy", busy1, 0);
    check("midrst_en_out", en_out1, 0);
    rst = 1'b1;
    bubble(3);
    beat(1, 1, fill_d(1), fill_w(1), 0);
    bubble(5);
    check("post_rst_dout", $signed(d_out1), 2);
    check("post_rst_err", err_out1, 0);

    check("queue_relu1_drained", q1.size(), 0);
    check("queue_relu0_drained", q0.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
